hilo_acc: RTL and testbench



---
 rtl/hilo_definition.sv | 31 +++
 rtl/div_core.sv | 87 ++++++++
 rtl/hilo_acc.sv | 180 ++++++++++++++++++
 tb/tb_hilo_acc.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_definition.sv
// rtl/hilo_definition.sv - shared constants and types for the HI/LO accumulator
// Purpose: Func codes for the SPECIAL and SPECIAL2 operations handled by hilo_acc,
//          the divide FSM state type and a magnitude helper for signed division.
// Ports:   none (package)
package hilo_definition;

    // SPECIAL space (ALUOp=1)
    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;

    // SPECIAL2 space (MULOp=1)
    localparam logic [5:0] FUNC_MADD  = 6'h00;
    localparam logic [5:0] FUNC_MADDU = 6'h01;
    localparam logic [5:0] FUNC_MSUB  = 6'h04;
    localparam logic [5:0] FUNC_MSUBU = 6'h05;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    // Absolute value when the operand is treated as signed; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude 2^31.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/div_core.sv
// rtl/div_core.sv - iterative 32-bit restoring divider with sign fixup
// Purpose: latches operand magnitudes on start, performs one shift-subtract step per
//          cycle for 32 cycles, then holds the signed/unsigned result for one DONE cycle.
// Ports:   clock, nreset     clock and asynchronous active-low reset
//          start, is_signed  begin a divide (only honoured in IDLE); signed operation
//          dividend, divisor operands, sampled on start
//          busy, done        FSM is in BUSY / DONE
//          quotient, remainder  sign-corrected results, valid while done
module div_core
    import hilo_definition::*;
(
    input  logic        clock,
    input  logic        nreset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_t  state;
    logic [4:0]  count;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] div_mag;
    logic        q_neg;
    logic        r_neg;

    // Partial remainder shifted left with the next dividend bit brought in.
    logic [32:0] shifted;
    logic        take;
    logic [31:0] trial;

    assign shifted = {rem_q, quo_q[31]};
    assign take    = (shifted >= {1'b0, div_mag});
    // When the subtraction is taken the difference is below div_mag, so 32 bits suffice.
    assign trial   = shifted[31:0] - div_mag;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            count   <= 5'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            div_mag <= 32'd0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        quo_q   <= magnitude(dividend, is_signed);
                        div_mag <= magnitude(divisor, is_signed);
                        rem_q   <= 32'd0;
                        q_neg   <= is_signed & (dividend[31] ^ divisor[31]);
                        r_neg   <= is_signed & dividend[31];
                        count   <= 5'd0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    rem_q <= take ? trial : shifted[31:0];
                    quo_q <= {quo_q[30:0], take};
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state == BUSY);
    assign done      = (state == DONE);
    assign quotient  = q_neg ? (32'd0 - quo_q) : quo_q;
    assign remainder = r_neg ? (32'd0 - rem_q) : rem_q;

endmodule

// File: rtl/hilo_acc.sv
// rtl/hilo_acc.sv - execute-stage HI/LO accumulator, mover and divider front end
// Purpose: holds HI/LO, performs MULT/MADD/MSUB/MTHI/MTLO/MFHI/MFLO and drives div_core
//          for DIV/DIVU, producing the ACC result, flags and pipeline stall.
// Ports:   clock, nreset          clock and asynchronous active-low reset
//          En, ALUOp, MULOp, Func operation valid and decode (SPECIAL / SPECIAL2)
//          MULout                 64-bit product from the multiplier
//          RegA, RegB             rs (move source / dividend), rt (divisor)
//          Out, O, Z, N, C        result and overflow/zero/negative/carry flags
//          Stall                  high while a divide is issuing or iterating
module hilo_acc
    import hilo_definition::*;
(
    input  logic        clock,
    input  logic        nreset,
    input  logic        En,
    input  logic        ALUOp,
    input  logic        MULOp,
    input  logic [5:0]  Func,
    input  logic [63:0] MULout,
    input  logic [31:0] RegA,
    input  logic [31:0] RegB,
    output logic [31:0] Out,
    output logic        O,
    output logic        Z,
    output logic        N,
    output logic        C,
    output logic        Stall
);

    logic [31:0] hi;
    logic [31:0] lo;

    logic [31:0] out_v;
    logic        o_v;
    logic        c_v;
    logic        flag_valid;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_d;
    logic [31:0] lo_d;

    logic        div_start;
    logic        div_signed;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    logic [64:0] sum;
    logic [64:0] diff;
    logic        add_ovf;
    logic        sub_ovf;

    // Bit 64 is the carry of the add and the borrow of the subtract.
    assign sum     = {1'b0, hi, lo} + {1'b0, MULout};
    assign diff    = {1'b0, hi, lo} - {1'b0, MULout};
    assign add_ovf = (hi[31] == MULout[63]) && (sum[63] != hi[31]);
    assign sub_ovf = (hi[31] != MULout[63]) && (diff[63] != hi[31]);

    assign div_signed = (Func == FUNC_DIV);

    always_comb begin
        out_v      = 32'd0;
        o_v        = 1'b0;
        c_v        = 1'b0;
        flag_valid = 1'b0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        hi_d       = hi;
        lo_d       = lo;
        div_start  = 1'b0;
        if (En && ALUOp) begin
            case (Func)
                FUNC_MFHI: begin
                    out_v = hi;
                    flag_valid = 1'b1;
                end
                FUNC_MFLO: begin
                    out_v = lo;
                    flag_valid = 1'b1;
                end
                FUNC_MTHI: begin
                    hi_we = 1'b1;
                    hi_d = RegA;
                    out_v = RegA;
                    flag_valid = 1'b1;
                end
                FUNC_MTLO: begin
                    lo_we = 1'b1;
                    lo_d = RegA;
                    out_v = RegA;
                    flag_valid = 1'b1;
                end
                FUNC_MULT, FUNC_MULTU: begin
                    hi_we = 1'b1;
                    lo_we = 1'b1;
                    {hi_d, lo_d} = MULout;
                    out_v = MULout[31:0];
                    flag_valid = 1'b1;
                end
                FUNC_DIV, FUNC_DIVU: begin
                    if (div_done) begin
                        out_v = div_quo;
                        flag_valid = 1'b1;
                    end else if (!div_busy && RegB != 32'd0) begin
                        // Gated by nreset so Stall drops the moment reset asserts.
                        div_start = nreset;
                    end
                end
                default: begin
                end
            endcase
        end else if (En && MULOp) begin
            case (Func)
                FUNC_MADD, FUNC_MADDU: begin
                    hi_we = 1'b1;
                    lo_we = 1'b1;
                    {hi_d, lo_d} = sum[63:0];
                    out_v = sum[31:0];
                    flag_valid = 1'b1;
                    o_v = (Func == FUNC_MADD) & add_ovf;
                    c_v = (Func == FUNC_MADDU) & sum[64];
                end
                FUNC_MSUB, FUNC_MSUBU: begin
                    hi_we = 1'b1;
                    lo_we = 1'b1;
                    {hi_d, lo_d} = diff[63:0];
                    out_v = diff[31:0];
                    flag_valid = 1'b1;
                    o_v = (Func == FUNC_MSUB) & sub_ovf;
                    c_v = (Func == FUNC_MSUBU) & diff[64];
                end
                default: begin
                end
            endcase
        end
        // The DIV stays frozen in EX until DONE, so the result commits in that cycle.
        if (div_done) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            hi_d  = div_rem;
            lo_d  = div_quo;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else begin
            if (hi_we) begin
                hi <= hi_d;
            end
            if (lo_we) begin
                lo <= lo_d;
            end
        end
    end

    div_core u_div_core (
        .clock     (clock),
        .nreset    (nreset),
        .start     (div_start),
        .is_signed (div_signed),
        .dividend  (RegA),
        .divisor   (RegB),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign Out   = out_v;
    assign O     = o_v;
    assign C     = c_v;
    assign Z     = flag_valid & (out_v == 32'd0);
    assign N     = flag_valid & out_v[31];
    assign Stall = div_start | div_busy;

endmodule

// File: tb/tb_hilo_acc.sv
// tb/tb_hilo_acc.sv - self-checking bench for hilo_acc
module tb_hilo_acc;

    logic        clock;
    logic        nreset;
    logic        En;
    logic        ALUOp;
    logic        MULOp;
    logic [5:0]  Func;
    logic [63:0] MULout;
    logic [31:0] RegA;
    logic [31:0] RegB;
    logic [31:0] Out;
    logic        O;
    logic        Z;
    logic        N;
    logic        C;
    logic        Stall;

    int checks = 0;
    int errors = 0;

    // Architectural HI/LO as a single 64-bit value {HI, LO}.
    logic [63:0] m_acc;

    hilo_acc dut (
        .clock  (clock),
        .nreset (nreset),
        .En     (En),
        .ALUOp  (ALUOp),
        .MULOp  (MULOp),
        .Func   (Func),
        .MULout (MULout),
        .RegA   (RegA),
        .RegB   (RegB),
        .Out    (Out),
        .O      (O),
        .Z      (Z),
        .N      (N),
        .C      (C),
        .Stall  (Stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Non-divide operation: model computes result from the ISA rules, then one cycle.
    task automatic do_op(input string tag, input bit en, input bit alu, input bit mul,
                         input logic [5:0] f, input logic [63:0] mo, input logic [31:0] a);
        logic [63:0] nacc;
        logic [31:0] eo;
        bit ec, eov, valid;
        logic signed [65:0] sx;
        nacc = m_acc; eo = 32'd0; ec = 0; eov = 0; valid = 0;
        if (en && alu) begin
            case (f)
                6'h10: begin eo = m_acc[63:32]; valid = 1; end
                6'h12: begin eo = m_acc[31:0]; valid = 1; end
                6'h11: begin nacc[63:32] = a; eo = a; valid = 1; end
                6'h13: begin nacc[31:0] = a; eo = a; valid = 1; end
                6'h18, 6'h19: begin nacc = mo; eo = mo[31:0]; valid = 1; end
                default: ;
            endcase
        end else if (en && mul) begin
            case (f)
                6'h00, 6'h01: begin
                    nacc = m_acc + mo;
                    eo = nacc[31:0];
                    valid = 1;
                    sx = $signed({{2{m_acc[63]}}, m_acc}) + $signed({{2{mo[63]}}, mo});
                    if (f == 6'h00) eov = (sx != $signed({{2{nacc[63]}}, nacc}));
                    else ec = (nacc < m_acc);
                end
                6'h04, 6'h05: begin
                    nacc = m_acc - mo;
                    eo = nacc[31:0];
                    valid = 1;
                    sx = $signed({{2{m_acc[63]}}, m_acc}) - $signed({{2{mo[63]}}, mo});
                    if (f == 6'h04) eov = (sx != $signed({{2{nacc[63]}}, nacc}));
                    else ec = (mo > m_acc);
                end
                default: ;
            endcase
        end
        En = en; ALUOp = alu; MULOp = mul; Func = f; MULout = mo; RegA = a;
        RegB = $urandom;
        #1;
        chk({tag, "_out"}, Out, eo);
        chk({tag, "_flags_ozcn"}, {O, Z, C, N}, {eov, valid && eo == 32'd0, ec, valid && eo[31]});
        chk({tag, "_stall"}, Stall, 1'b0);
        tick();
        m_acc = nacc;
        En = 0;
    endtask

    task automatic do_div(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] eq, er;
        int n;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        if (b != 32'd0) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = 0;
            r = 0;
        end
        eq = q[31:0];
        er = r[31:0];
        En = 1; ALUOp = 1; MULOp = 0; Func = sgn ? 6'h1A : 6'h1B; RegA = a; RegB = b;
        MULout = {$urandom, $urandom};
        #1;
        chk({tag, "_issue_out"}, Out, 32'd0);
        chk({tag, "_issue_flags"}, {O, Z, N, C}, 4'b0000);
        if (b == 32'd0) begin
            chk({tag, "_dz_stall"}, Stall, 1'b0);
            tick();
            chk({tag, "_dz_stall_after"}, Stall, 1'b0);
            En = 0;
            return;
        end
        chk({tag, "_issue_stall"}, Stall, 1'b1);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!Stall) break;
            n++;
        end
        chk({tag, "_stall_cycles"}, n, 33);
        chk({tag, "_quotient"}, Out, eq);
        chk({tag, "_done_flags_ozcn"}, {O, Z, C, N}, {1'b0, eq == 32'd0, 1'b0, eq[31]});
        tick();
        m_acc = {er, eq};
        En = 0;
        #1;
        chk({tag, "_no_reissue"}, Stall, 1'b0);
    endtask

    initial begin
        logic [5:0] alu_funcs [8];
        logic [5:0] mul_funcs [4];
        logic [5:0] bad_alu [4];
        logic [63:0] mo;
        int sel;
        alu_funcs = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h10, 6'h12};
        mul_funcs = '{6'h00, 6'h01, 6'h04, 6'h05};
        bad_alu   = '{6'h00, 6'h14, 6'h2A, 6'h1C};

        nreset = 0; En = 0; ALUOp = 0; MULOp = 0; Func = 0; MULout = 0; RegA = 0; RegB = 0;
        m_acc = 64'd0;
        #12;
        chk("reset_outputs", {Out, O, Z, N, C, Stall}, 37'd0);
        #1 nreset = 1;
        tick();

        // Reset then move
        do_op("mtlo", 1, 1, 0, 6'h13, 64'd0, 32'h12345678);
        do_op("mflo", 1, 1, 0, 6'h12, 64'd0, 32'd0);
        chk("mflo_model_lo", m_acc[31:0], 64'h12345678);

        // MULT then MADDU carry
        do_op("mult_ones", 1, 1, 0, 6'h18, 64'hFFFFFFFF_FFFFFFFF, 32'd0);
        do_op("maddu_carry", 1, 0, 1, 6'h01, 64'd1, 32'd0);
        do_op("mfhi_after_carry", 1, 1, 0, 6'h10, 64'd0, 32'd0);

        // MSUB signed overflow
        do_op("mthi_min", 1, 1, 0, 6'h11, 64'd0, 32'h80000000);
        do_op("mtlo_zero", 1, 1, 0, 6'h13, 64'd0, 32'h0);
        do_op("msub_ovf", 1, 0, 1, 6'h04, 64'd1, 32'd0);
        do_op("mfhi_after_msub", 1, 1, 0, 6'h10, 64'd0, 32'd0);

        // Signed / unsigned divide
        do_div("div_m7_2", 1, 32'hFFFFFFF9, 32'd2);
        do_op("div_mfhi", 1, 1, 0, 6'h10, 64'd0, 32'd0);
        do_op("div_mflo", 1, 1, 0, 6'h12, 64'd0, 32'd0);
        do_div("divu_m7_2", 0, 32'hFFFFFFF9, 32'd2);
        do_op("divu_mfhi", 1, 1, 0, 6'h10, 64'd0, 32'd0);
        do_op("divu_mflo", 1, 1, 0, 6'h12, 64'd0, 32'd0);
        do_div("div_min_m1", 1, 32'h80000000, 32'hFFFFFFFF);
        do_op("dmin_mfhi", 1, 1, 0, 6'h10, 64'd0, 32'd0);
        do_op("dmin_mflo", 1, 1, 0, 6'h12, 64'd0, 32'd0);

        // Divide by zero leaves HI/LO alone
        do_op("pre_hi", 1, 1, 0, 6'h11, 64'd0, 32'hA);
        do_op("pre_lo", 1, 1, 0, 6'h13, 64'd0, 32'hB);
        do_div("divu_zero", 0, 32'd55, 32'd0);
        do_op("dz_mfhi", 1, 1, 0, 6'h10, 64'd0, 32'd0);
        do_op("dz_mflo", 1, 1, 0, 6'h12, 64'd0, 32'd0);

        // Reset mid-divide at BUSY step 10
        En = 1; ALUOp = 1; MULOp = 0; Func = 6'h1B; RegA = 32'd100; RegB = 32'd3;
        #1;
        chk("rmd_issue_stall", Stall, 1'b1);
        tick();
        repeat (9) tick();
        chk("rmd_busy_stall", Stall, 1'b1);
        nreset = 0;
        #1;
        chk("rmd_stall_drop", Stall, 1'b0);
        Func = 6'h10;
        #1;
        chk("rmd_hi_zero", Out, 32'd0);
        Func = 6'h12;
        #1;
        chk("rmd_lo_zero", Out, 32'd0);
        En = 0;
        m_acc = 64'd0;
        tick();
        nreset = 1;
        tick();
        do_div("divu_100_3", 0, 32'd100, 32'd3);
        do_op("r_mfhi", 1, 1, 0, 6'h10, 64'd0, 32'd0);
        do_op("r_mflo", 1, 1, 0, 6'h12, 64'd0, 32'd0);
        chk("r_model_acc", m_acc, {32'd1, 32'd33});

        // Randomized mix of accumulator operations
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0: mo = {$urandom, $urandom};
                1: mo = {{32{1'b1}}, $urandom};
                2: mo = {32'h7FFFFFFF, $urandom};
                default: mo = {32'h0, $urandom};
            endcase
            if (sel < 5)
                do_op("rnd_alu", 1, 1, 0, alu_funcs[$urandom_range(0, 7)], mo, $urandom);
            else if (sel < 8)
                do_op("rnd_mac", 1, 0, 1, mul_funcs[$urandom_range(0, 3)], mo, $urandom);
            else if (sel == 8)
                do_op("rnd_unlisted", 1, 1, 0, bad_alu[$urandom_range(0, 3)], mo, $urandom);
            else
                do_op("rnd_disabled", 0, $urandom_range(0, 1), $urandom_range(0, 1),
                      mul_funcs[$urandom_range(0, 3)], mo, $urandom);
        end

        // Randomized divides
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 2 == 0) ? $urandom_range(1, 50) : $urandom;
            if (i == 3) b = 32'h0 - $urandom_range(1, 9);
            do_div("rnd_div", i % 2, a, b);
            do_op("rnd_div_mfhi", 1, 1, 0, 6'h10, 64'd0, 32'd0);
            do_op("rnd_div_mflo", 1, 1, 0, 6'h12, 64'd0, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
